// File: rtl/stopwatch_cu_pkg.sv
// Shared types and default field widths for the stopwatch control unit.
package stopwatch_cu_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  localparam int MSEC_W_DEF = 7;
  localparam int SEC_W_DEF  = 6;
  localparam int MIN_W_DEF  = 6;
  localparam int HOUR_W_DEF = 5;

endpackage

// File: rtl/stopwatch_cu_btn_edge_det.sv
// Rising-edge detector for a debounced button level; one event per press.
module btn_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  logic prev_q;

  // prev resets high so a button held through reset produces no event
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= i_btn;
  end

  assign o_rise = i_btn & ~prev_q;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: run/stop/clear FSM, lap freeze registers and display mux.
// state    | meaning
// ST_STOP  | datapath halted, waiting for run or clear
// ST_RUN   | datapath counting
// ST_CLEAR | datapath clear pulse, CLEAR_CYCLES long, buttons ignored
module stopwatch_cu
  import stopwatch_cu_pkg::*;
#(
  parameter int CLEAR_CYCLES = 1,
  parameter int MSEC_W       = MSEC_W_DEF,
  parameter int SEC_W        = SEC_W_DEF,
  parameter int MIN_W        = MIN_W_DEF,
  parameter int HOUR_W       = HOUR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_btn_run,
  input  logic              i_btn_clear,
  input  logic              i_btn_lap,
  input  logic [MSEC_W-1:0] i_msec,
  input  logic [SEC_W-1:0]  i_sec,
  input  logic [MIN_W-1:0]  i_min,
  input  logic [HOUR_W-1:0] i_hour,
  output logic              o_run_stop,
  output logic              o_clear,
  output logic              o_lap_active,
  output logic [MSEC_W-1:0] o_disp_msec,
  output logic [SEC_W-1:0]  o_disp_sec,
  output logic [MIN_W-1:0]  o_disp_min,
  output logic [HOUR_W-1:0] o_disp_hour
);

  localparam int               CNT_W    = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLEAR_CYCLES - 1);

  logic rise_run, rise_clear, rise_lap;

  btn_edge_det u_edge_run   (.clk(clk), .rst(rst), .i_btn(i_btn_run),   .o_rise(rise_run));
  btn_edge_det u_edge_clear (.clk(clk), .rst(rst), .i_btn(i_btn_clear), .o_rise(rise_clear));
  btn_edge_det u_edge_lap   (.clk(clk), .rst(rst), .i_btn(i_btn_lap),   .o_rise(rise_lap));

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                lap_active_q, lap_active_d;
  logic [MSEC_W-1:0]   lap_msec_q, lap_msec_d;
  logic [SEC_W-1:0]    lap_sec_q, lap_sec_d;
  logic [MIN_W-1:0]    lap_min_q, lap_min_d;
  logic [HOUR_W-1:0]   lap_hour_q, lap_hour_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_STOP;
      cnt_q        <= '0;
      lap_active_q <= 1'b0;
      lap_msec_q   <= '0;
      lap_sec_q    <= '0;
      lap_min_q    <= '0;
      lap_hour_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lap_active_q <= lap_active_d;
      lap_msec_q   <= lap_msec_d;
      lap_sec_q    <= lap_sec_d;
      lap_min_q    <= lap_min_d;
      lap_hour_q   <= lap_hour_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lap_active_d = lap_active_q;
    lap_msec_d   = lap_msec_q;
    lap_sec_d    = lap_sec_q;
    lap_min_d    = lap_min_q;
    lap_hour_d   = lap_hour_q;
    case (state_q)
      ST_STOP: begin
        if (rise_run) begin
          state_d = ST_RUN;
        end else if (rise_clear) begin
          state_d      = ST_CLEAR;
          cnt_d        = '0;
          lap_active_d = 1'b0;
          lap_msec_d   = '0;
          lap_sec_d    = '0;
          lap_min_d    = '0;
          lap_hour_d   = '0;
        end else if (rise_lap && lap_active_q) begin
          lap_active_d = 1'b0;
        end
      end
      ST_RUN: begin
        // run wins over lap; clear is not honoured while counting
        if (rise_run) begin
          state_d = ST_STOP;
        end else if (rise_lap) begin
          if (lap_active_q) begin
            lap_active_d = 1'b0;
          end else begin
            lap_active_d = 1'b1;
            lap_msec_d   = i_msec;
            lap_sec_d    = i_sec;
            lap_min_d    = i_min;
            lap_hour_d   = i_hour;
          end
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_run_stop   = (state_q == ST_RUN);
  assign o_clear      = (state_q == ST_CLEAR);
  assign o_lap_active = lap_active_q;
  assign o_disp_msec  = lap_active_q ? lap_msec_q : i_msec;
  assign o_disp_sec   = lap_active_q ? lap_sec_q  : i_sec;
  assign o_disp_min   = lap_active_q ? lap_min_q  : i_min;
  assign o_disp_hour  = lap_active_q ? lap_hour_q : i_hour;

endmodule

// File: tb/tb_stopwatch_cu.sv
// Directed bench for stopwatch_cu; a second instance covers the single-cycle clear.
module tb_stopwatch_cu;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_run, btn_clear, btn_lap;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] mins;
  logic [4:0] hour;

  logic       run3, clr3, lap3;
  logic [6:0] d_msec3;
  logic [5:0] d_sec3, d_min3;
  logic [4:0] d_hour3;
  logic       run1, clr1, lap1;
  logic [6:0] d_msec1;
  logic [5:0] d_sec1, d_min1;
  logic [4:0] d_hour1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_cu #(.CLEAR_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .i_btn_run(btn_run), .i_btn_clear(btn_clear), .i_btn_lap(btn_lap),
    .i_msec(msec), .i_sec(sec), .i_min(mins), .i_hour(hour),
    .o_run_stop(run3), .o_clear(clr3), .o_lap_active(lap3),
    .o_disp_msec(d_msec3), .o_disp_sec(d_sec3), .o_disp_min(d_min3), .o_disp_hour(d_hour3)
  );

  stopwatch_cu #(.CLEAR_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_btn_run(btn_run), .i_btn_clear(btn_clear), .i_btn_lap(btn_lap),
    .i_msec(msec), .i_sec(sec), .i_min(mins), .i_hour(hour),
    .o_run_stop(run1), .o_clear(clr1), .o_lap_active(lap1),
    .o_disp_msec(d_msec1), .o_disp_sec(d_sec1), .o_disp_min(d_min1), .o_disp_hour(d_hour1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    btn_run = 1'b1; tick(); btn_run = 1'b0;
  endtask

  task automatic pulse_clear();
    btn_clear = 1'b1; tick(); btn_clear = 1'b0;
  endtask

  task automatic pulse_lap();
    btn_lap = 1'b1; tick(); btn_lap = 1'b0;
  endtask

  task automatic set_live(input logic [6:0] m, input logic [5:0] s,
                          input logic [5:0] mi, input logic [4:0] h);
    msec = m; sec = s; mins = mi; hour = h;
  endtask

  function automatic logic [31:0] disp3();
    return {8'd0, d_hour3, d_min3, d_sec3, d_msec3};
  endfunction

  function automatic logic [31:0] pack(input logic [6:0] m, input logic [5:0] s,
                                       input logic [5:0] mi, input logic [4:0] h);
    return {8'd0, h, mi, s, m};
  endfunction

  initial begin
    int toggles, cl3, cl1;
    logic prev_run;

    rst = 1'b1; btn_run = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    set_live(7'd3, 6'd4, 6'd5, 5'd6);
    tick(); tick();
    chk("rst_run",   32'(run3), 32'd0);
    chk("rst_clear", 32'(clr3), 32'd0);
    chk("rst_lap",   32'(lap3), 32'd0);
    chk("rst_disp_live", disp3(), pack(7'd3, 6'd4, 6'd5, 5'd6));

    // button held through reset release gives no event
    btn_run = 1'b1; tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("held_thru_rst", 32'(run3), 32'd0);
    btn_run = 1'b0; tick();

    pulse_run();
    chk("t1_start", 32'(run3), 32'd1);
    tick();
    pulse_run();
    chk("t1_stop", 32'(run3), 32'd0);
    tick();

    btn_run = 1'b1; tick();
    chk("t2_first", 32'(run3), 32'd1);
    toggles = 0; prev_run = run3;
    for (int i = 0; i < 49; i++) begin
      tick();
      if (run3 !== prev_run) toggles++;
      prev_run = run3;
    end
    btn_run = 1'b0; tick();
    chk("t2_toggles", 32'(toggles), 32'd0);
    chk("t2_still_run", 32'(run3), 32'd1);
    pulse_run();
    chk("t2_stop", 32'(run3), 32'd0);
    tick();

    pulse_clear();
    cl3 = 0; cl1 = 0;
    for (int i = 0; i < 8; i++) begin
      cl3 += int'(clr3);
      cl1 += int'(clr1);
      if (run3) toggles++;
      tick();
    end
    chk("t3_clear_len3", 32'(cl3), 32'd3);
    chk("t3_clear_len1", 32'(cl1), 32'd1);
    chk("t3_no_run_in_clear", 32'(toggles), 32'd0);
    chk("t3_back_stop", 32'(clr3), 32'd0);

    pulse_run();
    chk("t3_run_after_clear", 32'(run3), 32'd1);
    tick();
    pulse_clear();
    chk("t3_clear_in_run", 32'(clr3), 32'd0);
    tick(); tick();
    chk("t3_clear_in_run_late", 32'(clr3), 32'd0);
    chk("t3_still_run", 32'(run3), 32'd1);

    set_live(7'd12, 6'd34, 6'd5, 5'd1);
    pulse_lap();
    chk("t4_lap_on", 32'(lap3), 32'd1);
    set_live(7'd50, 6'd35, 6'd5, 5'd1);
    tick();
    chk("t4_frozen", disp3(), pack(7'd12, 6'd34, 6'd5, 5'd1));
    pulse_run();
    chk("t4_persist_stop", 32'(lap3), 32'd1);
    chk("t4_frozen_stop", disp3(), pack(7'd12, 6'd34, 6'd5, 5'd1));
    tick();
    pulse_run();
    chk("t4_frozen_run", disp3(), pack(7'd12, 6'd34, 6'd5, 5'd1));
    tick();
    pulse_lap();
    chk("t4_lap_off", 32'(lap3), 32'd0);
    chk("t4_live", disp3(), pack(7'd50, 6'd35, 6'd5, 5'd1));
    tick();

    pulse_run();
    chk("t5_pre_stop", 32'(run3), 32'd0);
    tick();
    btn_run = 1'b1; btn_clear = 1'b1; btn_lap = 1'b1;
    tick();
    btn_run = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    chk("t5_run", 32'(run3), 32'd1);
    chk("t5_no_clear", 32'(clr3), 32'd0);
    chk("t5_no_lap", 32'(lap3), 32'd0);
    tick();
    chk("t5_no_clear_late", 32'(clr3), 32'd0);

    set_live(7'd20, 6'd10, 6'd3, 5'd2);
    pulse_lap();
    tick();
    pulse_run();
    chk("t6_lap_in_stop", 32'(lap3), 32'd1);
    tick();
    pulse_lap();
    chk("t6_stop_lap_off", 32'(lap3), 32'd0);
    tick();
    pulse_lap();
    chk("t6_stop_lap_ignored", 32'(lap3), 32'd0);
    tick();
    pulse_run(); tick();
    pulse_lap(); tick();
    pulse_run(); tick();
    chk("t6_relap_stop", 32'(lap3), 32'd1);
    set_live(7'd77, 6'd1, 6'd2, 5'd3);
    pulse_clear();
    chk("t6_clear_on", 32'(clr3), 32'd1);
    chk("t6_clear_lap_off", 32'(lap3), 32'd0);
    chk("t6_clear_live", disp3(), pack(7'd77, 6'd1, 6'd2, 5'd3));
    rst = 1'b1;
    tick();
    chk("t6_rst_clear", 32'(clr3), 32'd0);
    chk("t6_rst_run", 32'(run3), 32'd0);
    rst = 1'b0;
    tick();
    pulse_run();
    chk("t6_rst_to_stop", 32'(run3), 32'd1);
    tick();

    pulse_lap();
    chk("rst_lap_pre", 32'(lap3), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_lap", 32'(lap3), 32'd0);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
